dcache_bank_arbiter: RTL and testbench
======================================

# dcache_bank_arbiter

Bank-conflict arbiter and sequencer in front of the banked data cache. It accepts per-consumer read/write requests from LSUs, steers each request to the bank selected by its address, and shares each bank among competing consumers with per-bank round-robin. It relays bank responses back on the consumer valid/ready handshake. Requests to different banks proceed in parallel; requests to the same bank are serialized.

## Interface
Parameters:
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 8, number of requesters (LSUs)
- NUM_BANKS, 2, number of cache banks; power of two, ≥2
- OFFSET_BITS, 0, log2 of block size in bytes; bank index = addr[OFFSET_BITS +: $clog2(NUM_BANKS)]

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- consumer_read_valid  in  [NUM_CONSUMERS]  read request pending
- consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid
- consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  registered read data
- consumer_write_valid  in  [NUM_CONSUMERS]  write request pending
- consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
- consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write done
- bank_req_valid  out  [NUM_BANKS]  request to bank
- bank_req_write  out  [NUM_BANKS]  1 = write, 0 = read
- bank_req_address  out  ADDR_BITS x NUM_BANKS  full address
- bank_req_data  out  DATA_BITS x NUM_BANKS  write data
- bank_resp_valid  in  [NUM_BANKS]  bank completed request (one-cycle pulse or level; sampled only in REQUEST)
- bank_resp_data  in  DATA_BITS x NUM_BANKS  read data, valid with bank_resp_valid

## Operation
- Reset (async): all outputs 0, every bank FSM IDLE, every round-robin pointer 0, all busy flags 0.
- Per-bank FSM: IDLE → REQUEST → RELAY → IDLE.
- IDLE: eligible consumers are those with read_valid or write_valid, target address in this bank, and not busy. If a consumer has both valid, read wins and the write waits. Scan from ptr upward, wrapping NUM_CONSUMERS-1 → 0. The first eligible consumer is granted: latch its id, address, write flag and data; set busy[j]; set ptr = (j+1) mod NUM_CONSUMERS; assert bank_req_*; go to REQUEST. No eligible consumer: stay in IDLE, ptr unchanged.
- REQUEST: hold bank_req_* stable. On bank_resp_valid: drop bank_req_valid. For a read, set consumer_read_ready[j] and capture consumer_read_data[j] = bank_resp_data. For a write, set consumer_write_ready[j]. Go to RELAY.
- RELAY: wait for the relevant consumer valid[j] to be low. Then clear ready[j] and busy[j] and go to IDLE.
- A consumer is served by at most one bank at a time (busy flag), so per-consumer outputs are an OR across banks.
- Consumer address and data may change after grant; the latched copies are used.

## Timing
- Grant: request sampled at edge N → bank_req_valid high after edge N.
- Bank responds at edge M → ready high after edge M. Read latency = 2 edges plus bank latency.
- Consumer drops valid, sampled at edge K → ready low after edge K. Bank is IDLE after K and can grant again at edge K+1.
- Same bank, simultaneous requesters: one grant per bank per IDLE visit, round-robin order.
- Different banks: grants at the same edge, independent progress.
- Reset asserted mid-transaction: immediate return to reset state. In-flight requests are abandoned, and bank_req_valid drops without waiting for the edge.

## Structure
- Shared package dcache_pkg: bank FSM state enum (IDLE, REQUEST, RELAY; 2 bits) and bank_index function (address → bank).
- Sub-module rr_arbiter: one per bank. Inputs are request vector and ptr; outputs are grant valid and grant index, combinational. Ptr register stays in the parent.

## Test plan
- Single read: consumer 2 reads 0x10 (bank 0); bank 0 responds 0xAB one cycle after req. Expect bank_req_address[0]=0x10, write=0, then consumer_read_data[2]=0xAB with ready high until valid drops; total 3 edges.
- Single write: consumer 5 writes 0x3C to 0x21 (bank 1). Expect bank_req_write[1]=1, addr 0x21, data 0x3C, then consumer_write_ready[5] high, low one edge after valid drops.
- Bank conflict: consumers 0, 3, 6 all read bank 0 addresses from reset. Expect service order 0, 3, 6; then re-request by 0 and 3 with ptr=7 → order 0, 3.
- Parallel banks: consumer 1 reads 0x04 (bank 0) and consumer 4 reads 0x05 (bank 1) at the same edge. Expect both bank_req_valid high after the same edge and both readies together with equal bank latency.
- Read-over-write and busy: consumer 7 asserts read 0x02 and write 0x03 together. Expect read served first; write granted only after read relay completes.
- Reset mid-REQUEST: assert reset while bank_req_valid[0]=1. Expect all outputs 0 immediately (before the next edge); after release, ptr=0 and a fresh request completes normally.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and helpers for the data cache bank arbiter
package dcache_pkg;

    typedef enum logic [1:0] {
        BANK_IDLE    = 2'd0,
        BANK_REQUEST = 2'd1,
        BANK_RELAY   = 2'd2
    } bank_state_e;

    // Bank selected by an address: bank_bits bits just above the block offset
    function automatic int bank_index(input logic [31:0] addr,
                                      input int          offset_bits,
                                      input int          bank_bits);
        logic [31:0] mask;
        mask = (32'd1 << bank_bits) - 32'd1;
        return int'((addr >> offset_bits) & mask);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 gnt_valid_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int IW = $clog2(N);

    int k;

    // Scan from ptr upward with wrap-around; the first requester found wins
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        k           = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!gnt_valid_o && req_i[IW'(k)]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/dcache_bank_arbiter.sv
// rtl/dcache_bank_arbiter.sv - per-bank round-robin request steering and response relay
module dcache_bank_arbiter
    import dcache_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_BANKS     = 2,
    parameter int OFFSET_BITS   = 0
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_BANKS-1:0]                     bank_req_valid,
    output logic [NUM_BANKS-1:0]                     bank_req_write,
    output logic [NUM_BANKS-1:0][ADDR_BITS-1:0]      bank_req_address,
    output logic [NUM_BANKS-1:0][DATA_BITS-1:0]      bank_req_data,
    input  logic [NUM_BANKS-1:0]                     bank_resp_valid,
    input  logic [NUM_BANKS-1:0][DATA_BITS-1:0]      bank_resp_data
);

    localparam int CW = $clog2(NUM_CONSUMERS);
    localparam int BW = $clog2(NUM_BANKS);

    bank_state_e                            state_q [NUM_BANKS];
    logic [CW-1:0]                          ptr_q   [NUM_BANKS];
    logic [CW-1:0]                          owner_q [NUM_BANKS];
    logic [NUM_BANKS-1:0]                   req_valid_q;
    logic [NUM_BANKS-1:0]                   write_q;
    logic [NUM_BANKS-1:0][ADDR_BITS-1:0]    addr_q;
    logic [NUM_BANKS-1:0][DATA_BITS-1:0]    data_q;
    logic [NUM_CONSUMERS-1:0]               busy_q;
    logic [NUM_CONSUMERS-1:0]               read_ready_q;
    logic [NUM_CONSUMERS-1:0]               write_ready_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_q;

    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] sel_addr;
    logic [NUM_BANKS-1:0][NUM_CONSUMERS-1:0] bank_req_vec;
    logic                                    gnt_valid [NUM_BANKS];
    logic [CW-1:0]                           gnt_idx   [NUM_BANKS];

    // A consumer presents one request at a time (read beats write); route it to its bank unless busy
    always_comb begin
        sel_addr     = '0;
        bank_req_vec = '0;
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
            sel_addr[c] = consumer_read_valid[c] ? consumer_read_address[c]
                                                 : consumer_write_address[c];
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_req_vec[b][c] = (consumer_read_valid[c] || consumer_write_valid[c])
                                     && !busy_q[c]
                                     && (bank_index(32'(sel_addr[c]), OFFSET_BITS, BW) == b);
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
        rr_arbiter #(.N(NUM_CONSUMERS)) u_arb (
            .req_i       (bank_req_vec[b]),
            .ptr_i       (ptr_q[b]),
            .gnt_valid_o (gnt_valid[b]),
            .gnt_idx_o   (gnt_idx[b])
        );
    end

    // Per-bank IDLE/REQUEST/RELAY sequencers plus the per-consumer handshake registers they drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= BANK_IDLE;
                ptr_q[b]   <= '0;
                owner_q[b] <= '0;
            end
            req_valid_q   <= '0;
            write_q       <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            busy_q        <= '0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                unique case (state_q[b])
                    BANK_IDLE: begin
                        if (gnt_valid[b]) begin
                            owner_q[b]          <= gnt_idx[b];
                            write_q[b]          <= !consumer_read_valid[gnt_idx[b]];
                            addr_q[b]           <= sel_addr[gnt_idx[b]];
                            data_q[b]           <= consumer_write_data[gnt_idx[b]];
                            busy_q[gnt_idx[b]]  <= 1'b1;
                            ptr_q[b]            <= (gnt_idx[b] == CW'(NUM_CONSUMERS - 1))
                                                   ? '0 : gnt_idx[b] + 1'b1;
                            req_valid_q[b]      <= 1'b1;
                            state_q[b]          <= BANK_REQUEST;
                        end
                    end
                    BANK_REQUEST: begin
                        if (bank_resp_valid[b]) begin
                            req_valid_q[b] <= 1'b0;
                            if (write_q[b]) begin
                                write_ready_q[owner_q[b]] <= 1'b1;
                            end else begin
                                read_ready_q[owner_q[b]] <= 1'b1;
                                read_data_q[owner_q[b]]  <= bank_resp_data[b];
                            end
                            state_q[b] <= BANK_RELAY;
                        end
                    end
                    BANK_RELAY: begin
                        if (!(write_q[b] ? consumer_write_valid[owner_q[b]]
                                         : consumer_read_valid[owner_q[b]])) begin
                            read_ready_q[owner_q[b]]  <= 1'b0;
                            write_ready_q[owner_q[b]] <= 1'b0;
                            busy_q[owner_q[b]]        <= 1'b0;
                            state_q[b]                <= BANK_IDLE;
                        end
                    end
                    default: state_q[b] <= BANK_IDLE;
                endcase
            end
        end
    end

    assign bank_req_valid       = req_valid_q;
    assign bank_req_write       = write_q;
    assign bank_req_address     = addr_q;
    assign bank_req_data        = data_q;
    assign consumer_read_ready  = read_ready_q;
    assign consumer_write_ready = write_ready_q;
    assign consumer_read_data   = read_data_q;

endmodule

// File: tb/tb_dcache_bank_arbiter.sv
// tb/tb_dcache_bank_arbiter.sv - directed self-checking bench for dcache_bank_arbiter
module tb_dcache_bank_arbiter;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       rd_valid = '0;
    logic [7:0][7:0]  rd_addr = '0;
    logic [7:0]       rd_ready;
    logic [7:0][7:0]  rd_data;
    logic [7:0]       wr_valid = '0;
    logic [7:0][7:0]  wr_addr = '0;
    logic [7:0][7:0]  wr_data = '0;
    logic [7:0]       wr_ready;
    logic [1:0]       bq_valid;
    logic [1:0]       bq_write;
    logic [1:0][7:0]  bq_addr;
    logic [1:0][7:0]  bq_data;
    logic [1:0]       bs_valid = '0;
    logic [1:0][7:0]  bs_data = '0;

    int checks = 0;
    int errors = 0;

    dcache_bank_arbiter dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rd_valid),
        .consumer_read_address  (rd_addr),
        .consumer_read_ready    (rd_ready),
        .consumer_read_data     (rd_data),
        .consumer_write_valid   (wr_valid),
        .consumer_write_address (wr_addr),
        .consumer_write_data    (wr_data),
        .consumer_write_ready   (wr_ready),
        .bank_req_valid         (bq_valid),
        .bank_req_write         (bq_write),
        .bank_req_address       (bq_addr),
        .bank_req_data          (bq_data),
        .bank_resp_valid        (bs_valid),
        .bank_resp_data         (bs_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({bq_valid, bq_write, bq_addr, bq_data, rd_ready, wr_ready, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero valid=%b ready=%h exp all zero", bq_valid, rd_ready);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({bq_valid, rd_ready, wr_ready} !== '0) begin
            errors++;
            $display("FAIL reset_idle got valid=%b rdy=%h exp 0", bq_valid, rd_ready);
        end
    endtask

    task automatic test_single_read();
        rd_valid[2] = 1'b1;
        rd_addr[2]  = 8'h10;
        step();
        checks++;
        if (bq_valid !== 2'b01 || bq_addr[0] !== 8'h10 || bq_write[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_grant got v=%b a=%h w=%b exp v=01 a=10 w=0", bq_valid, bq_addr[0], bq_write[0]);
        end
        bs_valid[0] = 1'b1;
        bs_data[0]  = 8'hAB;
        step();
        bs_valid[0] = 1'b0;
        checks++;
        if (rd_ready !== 8'h04 || rd_data[2] !== 8'hAB || bq_valid !== 2'b00) begin
            errors++;
            $display("FAIL read_resp got rdy=%h d=%h v=%b exp rdy=04 d=ab v=00", rd_ready, rd_data[2], bq_valid);
        end
        step();
        checks++;
        if (rd_ready !== 8'h04) begin
            errors++;
            $display("FAIL read_hold got %h exp 04", rd_ready);
        end
        rd_valid[2] = 1'b0;
        step();
        checks++;
        if (rd_ready !== 8'h00) begin
            errors++;
            $display("FAIL read_release got %h exp 00", rd_ready);
        end
    endtask

    task automatic test_single_write();
        wr_valid[5] = 1'b1;
        wr_addr[5]  = 8'h21;
        wr_data[5]  = 8'h3C;
        step();
        checks++;
        if (bq_valid !== 2'b10 || bq_write[1] !== 1'b1 || bq_addr[1] !== 8'h21 || bq_data[1] !== 8'h3C) begin
            errors++;
            $display("FAIL write_grant got v=%b w=%b a=%h d=%h exp v=10 w=1 a=21 d=3c",
                     bq_valid, bq_write[1], bq_addr[1], bq_data[1]);
        end
        bs_valid[1] = 1'b1;
        step();
        bs_valid[1] = 1'b0;
        checks++;
        if (wr_ready !== 8'h20 || rd_ready !== 8'h00) begin
            errors++;
            $display("FAIL write_resp got wr=%h rd=%h exp wr=20 rd=00", wr_ready, rd_ready);
        end
        wr_valid[5] = 1'b0;
        step();
        checks++;
        if (wr_ready !== 8'h00) begin
            errors++;
            $display("FAIL write_release got %h exp 00", wr_ready);
        end
    endtask

    task automatic test_bank_conflict();
        int          cid  [5] = '{0, 3, 6, 0, 3};
        logic [7:0]  addr [5] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08};
        logic [7:0]  rdat;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_valid[cid[i]] = 1'b1;
            rd_addr[cid[i]]  = addr[i];
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                rd_valid[0] = 1'b1;
                rd_addr[0]  = 8'h06;
                rd_valid[3] = 1'b1;
                rd_addr[3]  = 8'h08;
            end
            step();
            checks++;
            if (bq_valid[0] !== 1'b1 || bq_addr[0] !== addr[i]) begin
                errors++;
                $display("FAIL conflict_order%0d got v=%b a=%h exp v=1 a=%h", i, bq_valid[0], bq_addr[0], addr[i]);
            end
            rdat = 8'h50 + 8'(i);
            bs_valid[0] = 1'b1;
            bs_data[0]  = rdat;
            step();
            bs_valid[0] = 1'b0;
            checks++;
            if (rd_ready !== (8'h01 << cid[i]) || rd_data[cid[i]] !== rdat) begin
                errors++;
                $display("FAIL conflict_resp%0d got rdy=%h d=%h exp rdy=%h d=%h",
                         i, rd_ready, rd_data[cid[i]], 8'h01 << cid[i], rdat);
            end
            rd_valid[cid[i]] = 1'b0;
            step();
        end
    endtask

    task automatic test_parallel_banks();
        rd_valid[1] = 1'b1;
        rd_addr[1]  = 8'h04;
        rd_valid[4] = 1'b1;
        rd_addr[4]  = 8'h05;
        step();
        checks++;
        if (bq_valid !== 2'b11 || bq_addr[0] !== 8'h04 || bq_addr[1] !== 8'h05) begin
            errors++;
            $display("FAIL parallel_grant got v=%b a0=%h a1=%h exp v=11 a0=04 a1=05", bq_valid, bq_addr[0], bq_addr[1]);
        end
        bs_valid = 2'b11;
        bs_data[0] = 8'h11;
        bs_data[1] = 8'h22;
        step();
        bs_valid = 2'b00;
        checks++;
        if (rd_ready !== 8'h12 || rd_data[1] !== 8'h11 || rd_data[4] !== 8'h22) begin
            errors++;
            $display("FAIL parallel_resp got rdy=%h d1=%h d4=%h exp rdy=12 d1=11 d4=22", rd_ready, rd_data[1], rd_data[4]);
        end
        rd_valid[1] = 1'b0;
        rd_valid[4] = 1'b0;
        step();
        checks++;
        if (rd_ready !== 8'h00 || bq_valid !== 2'b00) begin
            errors++;
            $display("FAIL parallel_release got rdy=%h v=%b exp 00/00", rd_ready, bq_valid);
        end
    endtask

    task automatic test_read_over_write();
        rd_valid[7] = 1'b1;
        rd_addr[7]  = 8'h02;
        wr_valid[7] = 1'b1;
        wr_addr[7]  = 8'h03;
        wr_data[7]  = 8'h5A;
        step();
        checks++;
        if (bq_valid !== 2'b01 || bq_addr[0] !== 8'h02 || bq_write[0] !== 1'b0) begin
            errors++;
            $display("FAIL rw_read_first got v=%b a=%h w=%b exp v=01 a=02 w=0", bq_valid, bq_addr[0], bq_write[0]);
        end
        bs_valid[0] = 1'b1;
        bs_data[0]  = 8'h77;
        step();
        bs_valid[0] = 1'b0;
        checks++;
        if (rd_ready !== 8'h80 || rd_data[7] !== 8'h77 || wr_ready !== 8'h00 || bq_valid !== 2'b00) begin
            errors++;
            $display("FAIL rw_read_resp got rdy=%h d=%h wr=%h v=%b exp 80/77/00/00", rd_ready, rd_data[7], wr_ready, bq_valid);
        end
        rd_valid[7] = 1'b0;
        step();
        checks++;
        if (rd_ready !== 8'h00 || bq_valid !== 2'b00) begin
            errors++;
            $display("FAIL rw_busy_hold got rdy=%h v=%b exp 00/00", rd_ready, bq_valid);
        end
        step();
        checks++;
        if (bq_valid !== 2'b10 || bq_write[1] !== 1'b1 || bq_addr[1] !== 8'h03 || bq_data[1] !== 8'h5A) begin
            errors++;
            $display("FAIL rw_write_grant got v=%b w=%b a=%h d=%h exp 10/1/03/5a", bq_valid, bq_write[1], bq_addr[1], bq_data[1]);
        end
        bs_valid[1] = 1'b1;
        step();
        bs_valid[1] = 1'b0;
        checks++;
        if (wr_ready !== 8'h80) begin
            errors++;
            $display("FAIL rw_write_resp got %h exp 80", wr_ready);
        end
        wr_valid[7] = 1'b0;
        step();
        checks++;
        if (wr_ready !== 8'h00) begin
            errors++;
            $display("FAIL rw_write_release got %h exp 00", wr_ready);
        end
    endtask

    task automatic test_reset_mid_request();
        rd_valid[2] = 1'b1;
        rd_addr[2]  = 8'h10;
        step();
        checks++;
        if (bq_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_grant got %b exp 1", bq_valid[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bq_valid, bq_write, bq_addr, bq_data, rd_ready, wr_ready, rd_data} !== '0) begin
            errors++;
            $display("FAIL mid_async_clear got v=%b a=%h d2=%h exp all zero", bq_valid, bq_addr[0], rd_data[2]);
        end
        rd_valid = '0;
        step();
        reset = 1'b0;
        rd_valid[1] = 1'b1;
        rd_addr[1]  = 8'h20;
        rd_valid[4] = 1'b1;
        rd_addr[4]  = 8'h40;
        step();
        checks++;
        if (bq_valid !== 2'b01 || bq_addr[0] !== 8'h20) begin
            errors++;
            $display("FAIL mid_ptr_reset got v=%b a=%h exp v=01 a=20", bq_valid, bq_addr[0]);
        end
        bs_valid[0] = 1'b1;
        bs_data[0]  = 8'h99;
        step();
        bs_valid[0] = 1'b0;
        checks++;
        if (rd_ready !== 8'h02 || rd_data[1] !== 8'h99) begin
            errors++;
            $display("FAIL mid_fresh_resp got rdy=%h d=%h exp 02/99", rd_ready, rd_data[1]);
        end
        rd_valid = '0;
        step();
        checks++;
        if (rd_ready !== 8'h00 || bq_valid !== 2'b00) begin
            errors++;
            $display("FAIL mid_fresh_release got rdy=%h v=%b exp 00/00", rd_ready, bq_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_bank_conflict();
        test_parallel_banks();
        test_read_over_write();
        test_reset_mid_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
